hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised hazard-detection and forwarding-control unit for the in-order MIPS pipeline. It sits beside the ID stage and tracks every in-flight register write in a shift-register scoreboard. From this it decides, per cycle, whether the ID instruction issues or stalls, and which in-flight producer each source operand forwards from. Beyond the fixed load-use/forwarding logic of the current pipeline, it adds configurable pipeline depth, configurable load latency, branch flush of wrong-path entries, a global freeze and a stall performance counter.

## Interface
- AW, 5, register-address width
- DEPTH, 3, tracked stages after ID (1=EX … DEPTH=WB)
- LOAD_LAT, 2, smallest distance at which load data is forwardable; 1 ≤ LOAD_LAT ≤ DEPTH
- FLUSH_DEPTH, 1, number of youngest in-flight entries killed by flush; FLUSH_DEPTH < DEPTH
- CW, 16, stall-counter width
- FW (derived), clog2(DEPTH+1), forward-code width

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  AW  source register numbers
- id_use_rs, id_use_rt  in  1  operand actually read
- id_wr_en  in  1  instruction writes a register
- id_wr_reg  in  AW  destination register
- id_is_load  in  1  result comes from data memory
- flush  in  1  taken branch/jump resolved; kill wrong path
- freeze  in  1  global pipeline hold (e.g. memory wait)
- stall  out  1  combinational; hold PC and IF/ID, insert bubble
- issue  out  1  combinational; ID instruction enters EX this edge
- ex_fwd_a, ex_fwd_b  out  FW  registered forward codes for the instruction now in EX
- ex_valid  out  1  registered; EX holds an issued instruction
- stall_cnt  out  CW  saturating count of stall cycles

## Operation
- Scoreboard entry e[k], k=1..DEPTH: {valid, wr, reg[AW-1:0], load}. e[k] is the instruction issued k cycles ago (excluding freeze cycles).
- Operand match for X ∈ {rs, rt}: use_X && X≠0 && e[k].valid && e[k].wr && e[k].reg==X. Select the youngest matching entry (smallest k); older matches are ignored.
- Hazard on X: youngest match has load=1 and k < LOAD_LAT.
- stall = id_valid && !flush && (hazard_rs || hazard_rt). freeze does not mask stall.
- issue = id_valid && !stall && !flush && !freeze.
- Forward code for X = k of the youngest match, else 0 (register file). Code k means "producer issued k cycles before the consumer"; the datapath maps k to a pipeline-register result.
- Insert record: {1, id_wr_en && id_wr_reg≠0, id_wr_reg, id_is_load}. A bubble is all-zero.

Per rising edge, evaluated in priority order:
- freeze=1: scoreboard, ex_fwd_*, ex_valid and stall_cnt all hold. A pending flush must be held high by upstream until freeze falls.
- flush=1:
  - Shift: e[k+1] ← e[k].
  - Entries landing at e[1..FLUSH_DEPTH+1] become bubbles.
  - e[1] gets a bubble; ex_valid ← 0; ex_fwd_* ← 0.
  - stall_cnt unchanged.
- Otherwise:
  - Shift: e[k+1] ← e[k], and e[DEPTH] retires.
  - e[1] ← insert record if issue, else bubble.
  - ex_valid ← issue.
  - ex_fwd_* ← codes if issue, else 0.
  - stall_cnt += 1 if stall, saturating at 2^CW−1.

## Timing
- Reset: every e[k] invalid; ex_fwd_a = ex_fwd_b = 0; ex_valid = 0; stall_cnt = 0. With an empty scoreboard, stall = 0 and issue = id_valid && !flush && !freeze.
- reset asserted mid-operation clears state immediately (asynchronously), regardless of clk, freeze or flush.
- stall and issue are combinational from same-cycle inputs plus scoreboard state; no registered latency.
- ex_fwd_*/ex_valid appear one edge after issue and stay aligned with the EX instruction.
- Load-use with LOAD_LAT=2: exactly 1 stall cycle when the load is at k=1. The consumer then issues with code 2.
- Writes to register 0 never create a match.
- A simultaneous flush and hazard produces no stall; flush wins.
- Self-dependence (rs==wr_reg in the same instruction) only matches older entries.

## Test plan
- Sequence: add r3,r1,r2 then sub r4,r3,r5 back-to-back → no stall; sub's ex_fwd_a=1, ex_fwd_b=0.
- Sequence: lw r2 then add r4,r2,r2 → stall=1 for exactly one cycle; stall_cnt 0→1; then issue with ex_fwd_a=ex_fwd_b=2.
- Sequence: add r3, add r3, then or r6,r3,r0 → ex_fwd_a=1 (youngest producer); ex_fwd_b=0 because r0 is never matched.
- Taken branch: add r7 issued, then flush=1 → the add's entry becomes a bubble after the edge. A following consumer of r7 gets code 0, ex_valid=0 for the flush cycle.
- Load-use stall with freeze=1 held for 3 cycles → stall stays 1, stall_cnt does not increment, scoreboard frozen. After release, one stall cycle is counted.
- Force stall for 2^CW+5 cycles (CW=4 build) → stall_cnt saturates at 15. Then drop reset low asynchronously between clock edges → all outputs return to reset values immediately.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard-detection and forwarding-control unit for the in-order pipeline.
// A shift-register scoreboard of in-flight writers drives stall/issue and forward codes.
module hazard_scoreboard #(
    parameter  int AW          = 5,
    parameter  int DEPTH       = 3,
    parameter  int LOAD_LAT    = 2,
    parameter  int FLUSH_DEPTH = 1,
    parameter  int CW          = 16,
    localparam int FW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wr_en,
    input  logic [AW-1:0] id_wr_reg,
    input  logic          id_is_load,
    input  logic          flush,
    input  logic          freeze,
    output logic          stall,
    output logic          issue,
    output logic [FW-1:0] ex_fwd_a,
    output logic [FW-1:0] ex_fwd_b,
    output logic          ex_valid,
    output logic [CW-1:0] stall_cnt
);

    typedef struct packed {
        logic          valid;
        logic          wr;
        logic [AW-1:0] rd;
        logic          load;
    } entry_t;

    entry_t        sb_q [1:DEPTH];
    entry_t        sb_d [1:DEPTH];
    logic [FW-1:0] ex_fwd_a_q, ex_fwd_a_d;
    logic [FW-1:0] ex_fwd_b_q, ex_fwd_b_d;
    logic          ex_valid_q, ex_valid_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    logic [FW-1:0] code_a, code_b;
    logic          hazard_a, hazard_b;
    entry_t        ins_rec;

    // Scan oldest to youngest so the youngest match (smallest k) wins.
    always_comb begin
        // NOTE: every signal gets a default first, otherwise a missed branch infers a latch.
        code_a   = '0;
        code_b   = '0;
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_use_rs && id_rs != '0 && sb_q[k].valid && sb_q[k].wr && sb_q[k].rd == id_rs) begin
                code_a   = FW'(k);
                hazard_a = sb_q[k].load && (k < LOAD_LAT);
            end
            if (id_use_rt && id_rt != '0 && sb_q[k].valid && sb_q[k].wr && sb_q[k].rd == id_rt) begin
                code_b   = FW'(k);
                hazard_b = sb_q[k].load && (k < LOAD_LAT);
            end
        end
    end

    assign stall = id_valid && !flush && (hazard_a || hazard_b);
    assign issue = id_valid && !stall && !flush && !freeze;

    always_comb begin
        ins_rec.valid = 1'b1;
        ins_rec.wr    = id_wr_en && (id_wr_reg != '0);
        ins_rec.rd    = id_wr_reg;
        ins_rec.load  = id_is_load;
    end

    always_comb begin
        sb_d        = sb_q;
        ex_fwd_a_d  = ex_fwd_a_q;
        ex_fwd_b_d  = ex_fwd_b_q;
        ex_valid_d  = ex_valid_q;
        stall_cnt_d = stall_cnt_q;
        if (!freeze) begin
            for (int k = DEPTH; k >= 2; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[1] = issue ? ins_rec : '0;
            if (flush) begin
                // Wrong-path entries are the youngest FLUSH_DEPTH, now shifted one slot older.
                for (int k = 1; k <= FLUSH_DEPTH + 1; k++) begin
                    sb_d[k] = '0;
                end
                ex_valid_d = 1'b0;
                ex_fwd_a_d = '0;
                ex_fwd_b_d = '0;
            end else begin
                ex_valid_d = issue;
                ex_fwd_a_d = issue ? code_a : '0;
                ex_fwd_b_d = issue ? code_b : '0;
                if (stall && stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the scoreboard is only DEPTH entries and must start invalid, so it is reset like any flop.
            for (int k = 1; k <= DEPTH; k++) begin
                sb_q[k] <= '0;
            end
            ex_fwd_a_q  <= '0;
            ex_fwd_b_q  <= '0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sb_q        <= sb_d;
            ex_fwd_a_q  <= ex_fwd_a_d;
            ex_fwd_b_q  <= ex_fwd_b_d;
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_fwd_a  = ex_fwd_a_q;
    assign ex_fwd_b  = ex_fwd_b_q;
    assign ex_valid  = ex_valid_q;
    assign stall_cnt = stall_cnt_q;

endmodule
